// File: rtl/punc_dmem_arbiter_pkg.sv
// Shared owner-state encodings, port ids and helpers for the PUnC data-memory arbiter.
package punc_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE     = 2'd0,
    OWN_CPU      = 2'd1,
    OWN_DBG_LOCK = 2'd2
  } own_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/punc_dmem_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, port_id} shift pipeline that follows each granted read to its return cycle.
module punc_rd_tag_pipe
  import punc_dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_port,
  output logic out_valid,
  output logic out_port
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] port_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      port_q  <= {RD_LAT{PORT_CPU}};
    end else begin
      valid_q[0] <= in_valid;
      port_q[0]  <= in_port;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_port  = port_q[RD_LAT-1];

endmodule

// File: rtl/punc_dmem_arbiter.sv
// Single-port PUnC memory arbiter between CPU (port 0) and debug/loader (port 1).
// Optional grant/conflict statistics outputs are enabled with `define PUNC_DMEM_ARB_STATS_EN.
module punc_dmem_arbiter
  import punc_dmem_arbiter_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef PUNC_DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_gnt,
  output logic [15:0]   stat_dbg_gnt,
  output logic [15:0]   stat_conflict
`endif
);

  localparam int              SW          = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_FULL = SW'(STARVE_MAX);

  own_e          state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          ret_valid, ret_port;

  always_ff @(posedge clk) begin
    if (rst) state_q <= OWN_NONE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = OWN_NONE;
    if (dbg_gnt)      state_d = dbg_lock ? OWN_DBG_LOCK : OWN_NONE;
    else if (cpu_gnt) state_d = OWN_CPU;
  end

  // OWN_CPU arbitrates exactly like OWN_NONE; only the lock state excludes the CPU.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state_q == OWN_DBG_LOCK) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (starve_q == STARVE_FULL) dbg_gnt = 1'b1;
        else                         cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    starve_d = '0;
    if (dbg_req && !dbg_gnt)
      starve_d = (starve_q == STARVE_FULL) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  always_comb begin
    mem_rd    = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
    mem_wr    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  punc_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_rd),
    .in_port   (dbg_gnt ? PORT_DBG : PORT_CPU),
    .out_valid (ret_valid),
    .out_port  (ret_port)
  );

  // Returning data passes straight through; each port otherwise shows its last captured word.
  always_comb begin
    cpu_rvalid  = ~rst & ret_valid & (ret_port == PORT_CPU);
    dbg_rvalid  = ~rst & ret_valid & (ret_port == PORT_DBG);
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (rst) begin
      cpu_rdata_d = '0;
      dbg_rdata_d = '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_d = mem_rdata;
      if (dbg_rvalid) dbg_rdata_d = mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rdata_d;
  assign dbg_rdata = dbg_rdata_d;

  always_ff @(posedge clk) begin
    cpu_rdata_q <= cpu_rdata_d;
    dbg_rdata_q <= dbg_rdata_d;
  end

`ifdef PUNC_DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_dbg_q, stat_conf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_q  <= '0;
      stat_dbg_q  <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_cpu_q  <= sat_inc16(stat_cpu_q, cpu_gnt);
      stat_dbg_q  <= sat_inc16(stat_dbg_q, dbg_gnt);
      stat_conf_q <= sat_inc16(stat_conf_q, cpu_req & dbg_req);
    end
  end

  assign stat_cpu_gnt  = stat_cpu_q;
  assign stat_dbg_gnt  = stat_dbg_q;
  assign stat_conflict = stat_conf_q;
`endif

endmodule
